// File: rtl/ipm_mask_seq_if.sv
// Handshake bundle between an IPM masking encoder and its producer/consumer.
// The master side supplies the job and the random bytes; the slave side is the encoder.
interface ipm_mask_seq_if #(
    parameter int V = 8
);
    logic           start;
    logic [7:0]     S;
    logic [V*8-1:0] L;
    logic [7:0]     rnd;
    logic           rnd_valid;
    logic           rnd_ready;
    logic [V*8-1:0] R;
    logic           out_valid;
    logic           out_ready;
    logic           busy;

    modport master (
        output start, S, L, rnd, rnd_valid, out_ready,
        input  rnd_ready, R, out_valid, busy
    );

    modport slave (
        input  start, S, L, rnd, rnd_valid, out_ready,
        output rnd_ready, R, out_valid, busy
    );
endinterface

// File: rtl/ipm_mask_seq.sv
// Sequential IPM masking encoder: splits secret S into shares R such that
// S = XOR_i L_i*R_i over GF(2^8), drawing one fresh random byte per share 1..V-1.
module ipm_mask_seq #(
    parameter int V = 8
) (
    input  logic            clk,
    input  logic            rst,
    ipm_mask_seq_if.slave   bus
);
    localparam int IW = $clog2(V);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [7:0]     acc_q, acc_d;
    logic [V*8-1:0] l_q, l_d;
    logic [V*8-1:0] r_q, r_d;
    logic           rnd_ready_q, rnd_ready_d;
    logic           out_valid_q, out_valid_d;
    logic           busy_q, busy_d;

    logic [7:0]     l_sel;
    logic [7:0]     prod;
    logic [7:0]     acc_next;
    logic           accept;
    logic           last;

    // Carry-less 8x8 product followed by reduction modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ (15'(a) << i);
        end
        for (int k = 14; k >= 8; k--) begin
            if (p[k]) p = p ^ (15'h11B << (k - 8));
        end
        return p[7:0];
    endfunction

    // Single shared multiplier: always weighs the incoming byte by the L of the current slot.
    assign l_sel    = l_q[{idx_q, 3'b000} +: 8];
    assign prod     = gf_mul(l_sel, bus.rnd);
    assign acc_next = acc_q ^ prod;
    assign accept   = (state_q == COLLECT) && bus.rnd_valid;
    assign last     = (idx_q == IW'(V - 1));

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        l_d     = l_q;
        r_d     = r_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Byte 0 of L is fixed to 1 by the scheme, whatever the caller drives.
                    l_d     = {bus.L[V*8-1:8], 8'h01};
                    acc_d   = bus.S;
                    idx_d   = IW'(1);
                    r_d     = '0;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (accept) begin
                    r_d[{idx_q, 3'b000} +: 8] = bus.rnd;
                    acc_d = acc_next;
                    idx_d = idx_q + IW'(1);
                    if (last) begin
                        // Share 0 closes the sum: with L_0=1 it absorbs S and all weighted shares.
                        r_d[7:0] = acc_next;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        rnd_ready_d = (state_d == COLLECT);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    // NOTE: the share register is reset too, so R reads as zero right after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= IW'(1);
            acc_q       <= '0;
            l_q         <= '0;
            r_q         <= '0;
            rnd_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            l_q         <= l_d;
            r_q         <= r_d;
            rnd_ready_q <= rnd_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.rnd_ready = rnd_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.R         = r_q;
endmodule

// File: tb/tb_ipm_mask_seq.sv
// Scoreboard bench for ipm_mask_seq: V=2 known-answer jobs and V=8 random,
// stalled, poked and reset-interrupted jobs, all checked against a GF(2^8) model.
module tb_ipm_mask_seq;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ipm_mask_seq_if #(.V(8)) bus8 ();
    ipm_mask_seq_if #(.V(2)) bus2 ();

    ipm_mask_seq #(.V(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    ipm_mask_seq #(.V(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference multiply by repeated xtime.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return r;
    endfunction

    task automatic run_job2(input logic [7:0] s, input logic [7:0] l1, input logic [7:0] rb,
                            input logic [7:0] exp_r0);
        bit got;
        @(negedge clk);
        bus2.start = 1'b1; bus2.S = s; bus2.L = {l1, 8'hFF};
        @(negedge clk);
        bus2.start = 1'b0; bus2.rnd_valid = 1'b1; bus2.rnd = rb;
        exp_q.push_back({48'h0, rb, exp_r0});
        @(negedge clk);
        bus2.rnd_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (bus2.out_valid) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk("v2_out_valid", got, 1'b1);
        chk("v2_sb_size", exp_q.size(), 1);
        if (exp_q.size() > 0) chk("v2_R", {48'h0, bus2.R}, exp_q.pop_front());
        bus2.out_ready = 1'b1;
        @(negedge clk);
        bus2.out_ready = 1'b0;
        chk("v2_idle_busy", bus2.busy, 1'b0);
        chk("v2_idle_valid", bus2.out_valid, 1'b0);
    endtask

    task automatic run_job8(input logic [7:0] s, input logic [63:0] l, input bit fixed,
                            input bit rand_valid, input int ready_delay, input bit poke);
        logic [63:0] r_exp, r_seen;
        logic [7:0]  acc, b, ip;
        int          consumed;
        bit          got, v;
        @(negedge clk);
        chk("idle_before", bus8.busy, 1'b0);
        bus8.start = 1'b1; bus8.S = s; bus8.L = l;
        @(negedge clk);
        bus8.start = 1'b0;
        chk("busy_after_start", bus8.busy, 1'b1);
        chk("R_cleared", bus8.R, 64'h0);
        if (poke) begin
            bus8.S = 8'($urandom);
            bus8.L = {$urandom, $urandom};
        end
        acc = s; r_exp = '0; consumed = 0; got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (bus8.out_valid) begin got = 1'b1; break; end
            chk("rnd_ready_collect", bus8.rnd_ready, 1'b1);
            v = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            b = fixed ? 8'(8'h10 + consumed + 1) : 8'($urandom);
            bus8.rnd_valid = v;
            bus8.rnd       = b;
            bus8.start     = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            if (v && bus8.rnd_ready) begin
                consumed++;
                if (consumed <= 7) begin
                    r_exp[consumed*8 +: 8] = b;
                    acc = acc ^ ref_mul(l[consumed*8 +: 8], b);
                    if (consumed == 7) begin
                        r_exp[7:0] = acc;
                        exp_q.push_back(r_exp);
                    end
                end
            end
            @(negedge clk);
        end
        bus8.rnd_valid = 1'b0;
        bus8.start     = 1'b0;
        chk("out_valid_seen", got, 1'b1);
        chk("consumed", consumed, 7);
        chk("sb_size", exp_q.size(), 1);
        r_seen = bus8.R;
        if (exp_q.size() > 0) chk("R", r_seen, exp_q.pop_front());
        chk("rnd_ready_done", bus8.rnd_ready, 1'b0);
        ip = r_seen[7:0];
        for (int i = 1; i < 8; i++) ip = ip ^ ref_mul(l[i*8 +: 8], r_seen[i*8 +: 8]);
        chk("inner_product", ip, s);
        for (int d = 0; d < ready_delay; d++) begin
            bus8.start = poke;
            bus8.rnd_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("hold_valid", bus8.out_valid, 1'b1);
            chk("hold_R", bus8.R, r_seen);
            chk("hold_rnd_ready", bus8.rnd_ready, 1'b0);
        end
        bus8.rnd_valid = 1'b0;
        bus8.start     = poke;
        bus8.out_ready = 1'b1;
        @(negedge clk);
        bus8.out_ready = 1'b0;
        bus8.start     = 1'b0;
        chk("drop_valid", bus8.out_valid, 1'b0);
        chk("drop_busy", bus8.busy, 1'b0);
        chk("R_kept_idle", bus8.R, r_seen);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] l_rand;
        rst = 1'b1;
        bus8.start = 0; bus8.S = 0; bus8.L = 0; bus8.rnd = 0; bus8.rnd_valid = 0; bus8.out_ready = 0;
        bus2.start = 0; bus2.S = 0; bus2.L = 0; bus2.rnd = 0; bus2.rnd_valid = 0; bus2.out_ready = 0;
        #12;
        chk("rst_R8", bus8.R, 64'h0);
        chk("rst_valid8", bus8.out_valid, 1'b0);
        chk("rst_ready8", bus8.rnd_ready, 1'b0);
        chk("rst_busy8", bus8.busy, 1'b0);
        chk("rst_R2", {48'h0, bus2.R}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        run_job2(8'h53, 8'h02, 8'hCA, 8'hDC);
        run_job2(8'h00, 8'h57, 8'h83, 8'hC1);

        run_job8(8'hA5, 64'h0000_0000_0000_0001, 1'b1, 1'b0, 0, 1'b0);
        chk("zeroL_R0", {56'h0, bus8.R[7:0]}, 64'hA5);
        chk("zeroL_R7", {56'h0, bus8.R[63:56]}, 64'h17);

        run_job8(8'($urandom), {$urandom, $urandom}, 1'b0, 1'b1, 3, 1'b1);

        // Async reset after three of seven bytes, asserted mid-cycle.
        @(negedge clk);
        bus8.start = 1'b1; bus8.S = 8'h3C; bus8.L = {$urandom, $urandom};
        @(negedge clk);
        bus8.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus8.rnd_valid = 1'b1; bus8.rnd = 8'($urandom);
            @(negedge clk);
        end
        bus8.rnd_valid = 1'b0;
        chk("mid_busy", bus8.busy, 1'b1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_R", bus8.R, 64'h0);
        chk("arst_busy", bus8.busy, 1'b0);
        chk("arst_valid", bus8.out_valid, 1'b0);
        chk("arst_ready", bus8.rnd_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        run_job8(8'h9E, {$urandom, $urandom}, 1'b0, 1'b0, 1, 1'b0);

        for (int it = 0; it < 1000; it++) begin
            l_rand = {$urandom, $urandom};
            run_job8(8'($urandom), l_rand, 1'b0, 1'b1, 3, 1'(it % 4 == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
